vx_mem_responder: RTL and testbench
===================================

// Module: vx_mem_responder
// PURPOSE
// - Memory-side endpoint of the L2/cluster memory interface: accepts mem_req_* from a cluster, returns read data on mem_rsp_*.
// - Backed by a byte-enabled on-chip word array with a fixed-latency read pipeline and an in-order response queue.
// - Used as the memory model behind a cluster in simulation and as the scratch memory in small FPGA builds.
// PARAMETERS
// DATA_WIDTH      512   line width in bits (multiple of 8); BYTEEN_WIDTH = DATA_WIDTH/8
// ADDR_WIDTH      26    line-address width
// TAG_WIDTH       8     request/response tag width, returned unmodified
// MEM_WORDS       1024  array depth in lines (power of 2); IDX_W = log2(MEM_WORDS) <= ADDR_WIDTH
// LATENCY         4     read accept-to-response cycles, >= 1
// RSP_QUEUE_SIZE  8     max outstanding reads (pipeline + queue), power of 2, >= LATENCY
// PORTS
// clk             in   1             clock, all state on rising edge
// reset           in   1             asynchronous, active-low reset
// mem_req_valid   in   1             request valid
// mem_req_rw      in   1             1 = write, 0 = read
// mem_req_byteen  in   BYTEEN_WIDTH  write byte enables (ignored on reads)
// mem_req_addr    in   ADDR_WIDTH    line address
// mem_req_data    in   DATA_WIDTH    write data
// mem_req_tag     in   TAG_WIDTH     request tag
// mem_req_ready   out  1             request accepted when valid & ready
// mem_rsp_valid   out  1             read response valid
// mem_rsp_data    out  DATA_WIDTH    read data
// mem_rsp_tag     out  TAG_WIDTH     tag of the originating read
// mem_rsp_ready   in   1             response consumed when valid & ready
// busy            out  1             reads outstanding
// err_count       out  16            out-of-range access count (see CONFIGURATION)
// BEHAVIOUR
// - Reset (reset==0, async): credits=RSP_QUEUE_SIZE, pipeline and queue emptied; mem_req_ready=0 while asserted, 1 from first cycle after release;
//   mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0, busy=0, err_count=0. Array contents not reset, retained across reset.
// - Reset mid-operation: all in-flight reads and queued responses discarded, no response issued for them; writes already accepted persist.
// - Index = mem_req_addr[IDX_W-1:0]; upper address bits wrap modulo MEM_WORDS (default build).
// - Credit counter (width log2(RSP_QUEUE_SIZE)+1): -1 on read accept, +1 on rsp handshake, unchanged if both in same cycle; never <0 or >RSP_QUEUE_SIZE.
// - mem_req_ready = (credits != 0) & out of reset; applies to reads and writes alike. busy = (credits != RSP_QUEUE_SIZE).
// - Write accept: bytes with byteen=1 updated at the accept edge; no response generated; byteen=0 -> accepted, no change.
// - Read accept at edge N: array read with N-edge contents (a write accepted at edge N-1 or earlier is visible);
//   {tag,data} enters a LATENCY-deep valid-tagged shift pipeline, pushed to queue at edge N+LATENCY-1.
// - mem_rsp_valid is registered queue-not-empty: earliest assertion in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after accept cycle.
// - Responses strictly in accept order; data/tag held stable while valid & !ready.
// - Queue cannot overflow: credit check guarantees space; push and pop in the same cycle both take effect, including when full.
// - Back-to-back reads at 1/cycle sustained while mem_rsp_ready=1 and RSP_QUEUE_SIZE >= LATENCY+1.
// CONFIGURATION
// - VX_MEM_RSP_BOUNDS_CHECK_EN defined: address with any bit set at or above IDX_W is out of range;
//   out-of-range writes are accepted and dropped, out-of-range reads return all-ones data with correct tag and timing;
//   err_count +1 per out-of-range accept, saturating at 16'hFFFF.
// - Not defined: addresses wrap modulo MEM_WORDS, err_count tied to 0.
// TESTING
// - Write addr 0x10 data=0xA5.. byteen all 1, then read 0x10 tag 0x3 -> one response LATENCY cycles after read accept, data 0xA5.., tag 0x3.
// - Write 0x20 all-0, then byteen=0x1 data byte0=0x7F; read -> byte0=0x7F, remaining bytes 0.
// - mem_rsp_ready=0, issue 9 reads (size 8) -> 8 accepted, ready=0 on 9th; raise rsp_ready -> 8 responses in order, 9th accepted after first pop.
// - Reads every cycle with rsp_ready=1 for 32 cycles -> ready stays 1, 32 in-order responses, busy drops LATENCY cycles after last accept.
// - 3 reads in flight, assert reset for 1 cycle -> no responses emitted; earlier written data still readable after release.
// - With VX_MEM_RSP_BOUNDS_CHECK_EN, read addr MEM_WORDS -> all-ones data, err_count=1; without, returns contents of line 0.

Source files
------------

// File: rtl/vx_mem_responder.sv
// vx_mem_responder: byte-enabled line memory with a fixed-latency read pipeline and an in-order response queue.
// Optional feature macro: VX_MEM_RSP_BOUNDS_CHECK_EN (flag, drop/force out-of-range accesses and count them).

module vx_mem_responder #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int MEM_WORDS      = 1024,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    busy,
    output logic [15:0]             err_count
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int QPTR_W = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
    localparam int CNT_W  = $clog2(RSP_QUEUE_SIZE) + 1;
    localparam logic [CNT_W-1:0]  FULL_CREDITS = CNT_W'(RSP_QUEUE_SIZE);
    localparam logic [QPTR_W-1:0] LAST_SLOT    = QPTR_W'(RSP_QUEUE_SIZE - 1);

`ifdef VX_MEM_RSP_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] memArray [MEM_WORDS];
    logic [DATA_WIDTH-1:0] qData    [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]  qTag     [RSP_QUEUE_SIZE];

    logic                  reqOutOfRange, oobAccess;
    logic                  reqFire, rdFire, wrFire, rspPop;
    logic [IDX_W-1:0]      reqIdx;
    logic [DATA_WIDTH-1:0] rdData;

    logic                  pushValid;
    logic [TAG_WIDTH-1:0]  pushTag;
    logic [DATA_WIDTH-1:0] pushData;

    logic                  readyEn_q;
    logic [CNT_W-1:0]      creditCnt_q, creditCnt_d;
    logic [CNT_W-1:0]      qCount_q, qCount_d, qRemain;
    logic [QPTR_W-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic                  rspValid_q, rspValid_d;
    logic [DATA_WIDTH-1:0] rspData_q, rspData_d;
    logic [TAG_WIDTH-1:0]  rspTag_q, rspTag_d;

    function automatic logic [QPTR_W-1:0] ptrInc(input logic [QPTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign reqIdx        = mem_req_addr[IDX_W-1:0];
    assign reqOutOfRange = (mem_req_addr >> IDX_W) != '0;
    assign oobAccess     = BOUNDS_CHECK & reqOutOfRange;

    // Writes need a credit too, so a full response path also stalls writes.
    assign mem_req_ready = readyEn_q & (creditCnt_q != '0);
    assign reqFire       = mem_req_valid & mem_req_ready;
    assign rdFire        = reqFire & ~mem_req_rw;
    assign wrFire        = reqFire & mem_req_rw & ~oobAccess;
    assign rspPop        = rspValid_q & mem_rsp_ready;

    assign rdData = oobAccess ? '1 : memArray[reqIdx];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wrFire && mem_req_byteen[b]) begin
                memArray[reqIdx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign pushValid = rdFire;
            assign pushTag   = mem_req_tag;
            assign pushData  = rdData;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;
            logic                  pipeValid_q [STAGES];
            logic [TAG_WIDTH-1:0]  pipeTag_q   [STAGES];
            logic [DATA_WIDTH-1:0] pipeData_q  [STAGES];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < STAGES; s++) begin
                        pipeValid_q[s] <= 1'b0;
                        pipeTag_q[s]   <= '0;
                        pipeData_q[s]  <= '0;
                    end
                end else begin
                    pipeValid_q[0] <= rdFire;
                    pipeTag_q[0]   <= mem_req_tag;
                    pipeData_q[0]  <= rdData;
                    for (int s = 1; s < STAGES; s++) begin
                        pipeValid_q[s] <= pipeValid_q[s-1];
                        pipeTag_q[s]   <= pipeTag_q[s-1];
                        pipeData_q[s]  <= pipeData_q[s-1];
                    end
                end
            end

            assign pushValid = pipeValid_q[STAGES-1];
            assign pushTag   = pipeTag_q[STAGES-1];
            assign pushData  = pipeData_q[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (pushValid) begin
            qData[wrPtr_q] <= pushData;
            qTag[wrPtr_q]  <= pushTag;
        end
    end

    // The output register always holds the post-edge queue head, so the
    // pushed entry bypasses storage when it lands in an otherwise empty queue.
    always_comb begin
        wrPtr_d     = pushValid ? ptrInc(wrPtr_q) : wrPtr_q;
        rdPtr_d     = rspPop ? ptrInc(rdPtr_q) : rdPtr_q;
        qRemain     = qCount_q - CNT_W'(rspPop);
        qCount_d    = qRemain + CNT_W'(pushValid);
        creditCnt_d = creditCnt_q - CNT_W'(rdFire) + CNT_W'(rspPop);
        rspValid_d  = (qCount_d != '0);
        rspData_d   = '0;
        rspTag_d    = '0;
        if (qRemain != '0) begin
            rspData_d = qData[rdPtr_d];
            rspTag_d  = qTag[rdPtr_d];
        end else if (pushValid) begin
            rspData_d = pushData;
            rspTag_d  = pushTag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readyEn_q   <= 1'b0;
            creditCnt_q <= FULL_CREDITS;
            qCount_q    <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            rspValid_q  <= 1'b0;
            rspData_q   <= '0;
            rspTag_q    <= '0;
        end else begin
            readyEn_q   <= 1'b1;
            creditCnt_q <= creditCnt_d;
            qCount_q    <= qCount_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            rspValid_q  <= rspValid_d;
            rspData_q   <= rspData_d;
            rspTag_q    <= rspTag_d;
        end
    end

    assign mem_rsp_valid = rspValid_q;
    assign mem_rsp_data  = rspData_q;
    assign mem_rsp_tag   = rspTag_q;
    assign busy          = (creditCnt_q != FULL_CREDITS);

`ifdef VX_MEM_RSP_BOUNDS_CHECK_EN
    logic [15:0] errCount_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errCount_q <= '0;
        end else if (reqFire && reqOutOfRange && errCount_q != 16'hFFFF) begin
            errCount_q <= errCount_q + 16'd1;
        end
    end

    assign err_count = errCount_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed testbench for vx_mem_responder: writes, byte masking, backpressure, streaming, mid-flight reset, wraparound.

module tb_vx_mem_responder;

   localparam int DW    = 512;
   localparam int AW    = 26;
   localparam int TW    = 8;
   localparam int WORDS = 1024;
   localparam int LAT   = 4;
   localparam int QS    = 8;

   logic            clk = 1'b0;
   logic            resetN;
   logic            reqValid, reqRw, reqReady;
   logic [DW/8-1:0] reqByteen;
   logic [AW-1:0]   reqAddr;
   logic [DW-1:0]   reqData;
   logic [TW-1:0]   reqTag;
   logic            rspValid, rspReady, busy;
   logic [DW-1:0]   rspData;
   logic [TW-1:0]   rspTag;
   logic [15:0]     errCount;

   int passCnt  = 0;
   int checkCnt = 0;
   int edgeCnt  = 0;

   logic [DW-1:0] rxData [$];
   logic [TW-1:0] rxTag  [$];

   vx_mem_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
      .MEM_WORDS(WORDS), .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
   ) dut (
      .clk(clk), .reset(resetN),
      .mem_req_valid(reqValid), .mem_req_rw(reqRw), .mem_req_byteen(reqByteen),
      .mem_req_addr(reqAddr), .mem_req_data(reqData), .mem_req_tag(reqTag),
      .mem_req_ready(reqReady),
      .mem_rsp_valid(rspValid), .mem_rsp_data(rspData), .mem_rsp_tag(rspTag),
      .mem_rsp_ready(rspReady),
      .busy(busy), .err_count(errCount)
   );

   // Free-running clock plus an edge counter used to measure latencies.
   always #5 clk = ~clk;
   always @(posedge clk) edgeCnt++;

   // Record every response handshake, sampled mid-cycle when everything is stable.
   always @(negedge clk) begin
      if (resetN && rspValid && rspReady) begin
         rxData.push_back(rspData);
         rxTag.push_back(rspTag);
      end
   end

   // Hard stop in case some sequence stalls beyond all of its own bounds.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checkCnt++;
      if (obs === exp) passCnt++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
   endtask

   task automatic applyStimulus(input logic valid, input logic rw, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [DW/8-1:0] be, input logic [TW-1:0] tag);
      reqValid  = valid;
      reqRw     = rw;
      reqAddr   = addr;
      reqData   = data;
      reqByteen = be;
      reqTag    = tag;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pattern(input int i);
      logic [7:0] b;
      b = 8'(8'h10 + i);
      return {64{b}};
   endfunction

   task automatic writeLine(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DW/8-1:0] be);
      applyStimulus(1'b1, 1'b1, addr, data, be, '0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   // Single read with rspReady held high; checks data, tag, latency and busy while in flight.
   task automatic readWait(input string name, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] expData);
      int  t0;
      bit  seen;
      seen = 1'b0;
      applyStimulus(1'b1, 1'b0, addr, '0, '0, tag);
      t0 = edgeCnt;
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rspValid) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) begin
         checkOutput({name, "_data"}, rspData, expData);
         checkOutput({name, "_tag"}, DW'(rspTag), DW'(tag));
         checkOutput({name, "_latency"}, DW'(edgeCnt - t0), DW'(LAT));
         checkOutput({name, "_busy"}, DW'(busy), DW'(1));
      end else begin
         checkOutput({name, "_timeout"}, DW'(0), DW'(1));
      end
      nextCycle();
   endtask

   initial begin
      int  readyHigh;
      int  lastAccept;
      bit  got;
      resetN   = 1'b0;
      rspReady = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);

      // Reset state
      @(negedge clk);
      checkOutput("rst_ready", DW'(reqReady), DW'(0));
      checkOutput("rst_rsp_valid", DW'(rspValid), DW'(0));
      checkOutput("rst_rsp_data", rspData, '0);
      checkOutput("rst_rsp_tag", DW'(rspTag), DW'(0));
      checkOutput("rst_busy", DW'(busy), DW'(0));
      checkOutput("rst_err_count", DW'(errCount), DW'(0));
      resetN = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_release", DW'(reqReady), DW'(1));
      nextCycle();
      rspReady = 1'b1;

      // Full-line write then read back
      writeLine(26'h10, {64{8'hA5}}, '1);
      readWait("full_line", 26'h10, 8'h03, {64{8'hA5}});
      @(negedge clk);
      checkOutput("full_line_single_rsp", DW'(rspValid), DW'(0));
      checkOutput("full_line_idle_busy", DW'(busy), DW'(0));
      nextCycle();

      // Partial byte-enable write
      writeLine(26'h20, '0, '1);
      writeLine(26'h20, {{63{8'hEE}}, 8'h7F}, 64'h1);
      readWait("partial", 26'h20, 8'h07, 512'h7F);

      // Backpressure: 8 reads fill every credit, the 9th waits for the first pop
      for (int i = 0; i < 9; i++) writeLine(AW'(26'h40 + i), pattern(i), '1);
      rxData.delete();
      rxTag.delete();
      rspReady  = 1'b0;
      readyHigh = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, AW'(26'h40 + i), '0, '0, TW'(i));
         @(negedge clk);
         if (reqReady) readyHigh++;
         nextCycle();
      end
      checkOutput("bp_first8_ready", DW'(readyHigh), DW'(8));
      applyStimulus(1'b1, 1'b0, 26'h48, '0, '0, 8'h08);
      @(negedge clk);
      checkOutput("bp_ninth_blocked", DW'(reqReady), DW'(0));
      repeat (6) nextCycle();
      @(negedge clk);
      checkOutput("bp_head_valid", DW'(rspValid), DW'(1));
      checkOutput("bp_head_tag_held", DW'(rspTag), DW'(0));
      checkOutput("bp_head_data_held", rspData, pattern(0));
      checkOutput("bp_still_blocked", DW'(reqReady), DW'(0));
      nextCycle();
      rspReady = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (reqReady) begin
            got = 1'b1;
            break;
         end
         nextCycle();
      end
      checkOutput("bp_ninth_ready", DW'(got), DW'(1));
      nextCycle();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
      for (int k = 0; k < 40 && rxTag.size() < 9; k++) nextCycle();
      checkOutput("bp_rsp_count", DW'(rxTag.size()), DW'(9));
      for (int i = 0; i < 9 && i < rxTag.size(); i++) begin
         checkOutput($sformatf("bp_tag%0d", i), DW'(rxTag[i]), DW'(i));
         checkOutput($sformatf("bp_data%0d", i), rxData[i], pattern(i));
      end

      // Streaming: one read per cycle for 32 cycles
      repeat (3) nextCycle();
      rxData.delete();
      rxTag.delete();
      readyHigh = 0;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'b0, AW'(26'h40 + (i % 8)), '0, '0, TW'(8'h80 + i));
         @(negedge clk);
         if (reqReady) readyHigh++;
         nextCycle();
      end
      lastAccept = edgeCnt;
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
      checkOutput("stream_ready_high", DW'(readyHigh), DW'(32));
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!busy) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("stream_busy_drop", DW'(got), DW'(1));
      checkOutput("stream_busy_drop_time", DW'(edgeCnt - lastAccept), DW'(LAT));
      repeat (4) nextCycle();
      checkOutput("stream_rsp_count", DW'(rxTag.size()), DW'(32));
      for (int i = 0; i < 32 && i < rxTag.size(); i++) begin
         checkOutput($sformatf("stream_tag%0d", i), DW'(rxTag[i]), DW'(8'h80 + i));
         checkOutput($sformatf("stream_data%0d", i), rxData[i], pattern(i % 8));
      end

      // Reset with three reads in flight: nothing comes out, memory survives
      rxData.delete();
      rxTag.delete();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, AW'(26'h40 + i), '0, '0, TW'(8'h30 + i));
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
      resetN = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", DW'(busy), DW'(0));
      checkOutput("midrst_rsp_valid", DW'(rspValid), DW'(0));
      checkOutput("midrst_ready", DW'(reqReady), DW'(0));
      nextCycle();
      resetN = 1'b1;
      repeat (10) nextCycle();
      checkOutput("midrst_no_rsp", DW'(rxTag.size()), DW'(0));
      readWait("after_reset", 26'h10, 8'h09, {64{8'hA5}});

      // Address MEM_WORDS: wraps to line 0, or is flagged when bounds checking is built in
      writeLine(26'h0, {64{8'h5C}}, '1);
`ifdef VX_MEM_RSP_BOUNDS_CHECK_EN
      readWait("oob", AW'(WORDS), 8'h05, '1);
      @(negedge clk);
      checkOutput("oob_err_count", DW'(errCount), DW'(1));
`else
      readWait("wrap", AW'(WORDS), 8'h05, {64{8'h5C}});
      @(negedge clk);
      checkOutput("wrap_err_count", DW'(errCount), DW'(0));
`endif

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
